// File: rtl/rns_pkg.sv
// ---------------------------------------------------------------------------
// rns_pkg
// Shared definitions for the RNS datapath channels.
//   rns_state_e : state encoding of the sequential reduction FSM
//                 (IDLE=0, RUN=1, DONE=2)
//   RNS_M0..M2  : default channel moduli
//   RNS_PROD_W  : width of the 6x3 multiplier product feeding the reducers
// ---------------------------------------------------------------------------
package rns_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rns_state_e;

  localparam int RNS_M0     = 7;
  localparam int RNS_M1     = 8;
  localparam int RNS_M2     = 5;
  localparam int RNS_PROD_W = 9;

endpackage

// File: rtl/rns_cond_sub_step.sv
// ---------------------------------------------------------------------------
// rns_cond_sub_step
// One step of MSB-first restoring division by a constant modulus.
// Shifts the next operand bit into the partial remainder and subtracts the
// modulus when the shifted value reaches it.
//   rem_in  [OUT_W:0] : current partial remainder (always < MODULUS)
//   bit_in            : next operand bit, MSB first
//   rem_out [OUT_W:0] : next partial remainder (always < MODULUS)
//   q_bit             : quotient bit produced by this step
// Purely combinational so it can be chained for an unrolled pipeline.
// ---------------------------------------------------------------------------
module rns_cond_sub_step #(
  parameter int OUT_W   = 3,
  parameter int MODULUS = 7
) (
  input  logic [OUT_W:0] rem_in,
  input  logic           bit_in,
  output logic [OUT_W:0] rem_out,
  output logic           q_bit
);

  // The shifted value is kept one bit wider than strictly needed so the
  // whole remainder register can be shifted in without a truncation; since
  // rem_in < MODULUS <= 2**OUT_W the top bit is always zero in practice.
  localparam int T_W = OUT_W + 2;
  localparam logic [T_W-1:0] MOD_T = T_W'(MODULUS);

  logic [T_W-1:0] t;

  // Shift-in followed by an unsigned compare/subtract. t < 2*MODULUS, so a
  // single conditional subtraction always leaves a value below MODULUS.
  always_comb begin
    t       = {rem_in, bit_in};
    q_bit   = (t >= MOD_T);
    rem_out = q_bit ? (OUT_W+1)'(t - MOD_T) : t[OUT_W:0];
  end

endmodule

// File: rtl/rns_mod_reduce_seq.sv
// ---------------------------------------------------------------------------
// rns_mod_reduce_seq
// Sequential modular reduction of a binary product for one RNS channel.
// One operand bit is processed per clock, MSB first, producing both the
// residue (in_data mod MODULUS) and the quotient (in_data div MODULUS).
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   in_valid     : product on in_data is valid
//   in_ready     : high only in IDLE; the accept edge latches in_data
//   in_data      : IN_W-bit product
//   out_valid    : residue/quotient valid, held until out_ready
//   out_ready    : consumer accepts the result
//   out_residue  : OUT_W-bit residue
//   out_quotient : IN_W-bit quotient
// Result appears IN_W edges after the accept edge; one result per IN_W+2
// cycles when streaming with no backpressure.
// ---------------------------------------------------------------------------
module rns_mod_reduce_seq
  import rns_pkg::*;
#(
  parameter int IN_W    = RNS_PROD_W,
  parameter int OUT_W   = 3,
  parameter int MODULUS = RNS_M0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_residue,
  output logic [IN_W-1:0]   out_quotient
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  // A modulus outside [2, 2**OUT_W] cannot be represented by the residue
  // port or would make the reduction meaningless, so refuse to elaborate.
  if (MODULUS < 2 || MODULUS > (1 << OUT_W)) begin : g_bad_modulus
    $fatal(1, "rns_mod_reduce_seq: MODULUS %0d outside [2, 2**OUT_W]", MODULUS);
  end

  rns_state_e        state_q, state_d;
  logic [IN_W-1:0]   operand_q, operand_d;
  logic [IN_W-1:0]   quot_q, quot_d;
  logic [OUT_W:0]    rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [OUT_W:0]    step_rem;
  logic              step_q_bit;

  // The datapath step always looks at the operand bit selected by the
  // counter; its result is only committed while in RUN.
  rns_cond_sub_step #(
    .OUT_W   (OUT_W),
    .MODULUS (MODULUS)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (operand_q[cnt_q]),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  // Next-state and datapath update. Every register defaults to holding, so
  // the DONE state naturally keeps the result stable under backpressure.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          operand_d = in_data;
          rem_d     = '0;
          quot_d    = '0;
          cnt_d     = CNT_W'(IN_W - 1);
          state_d   = RUN;
        end
      end

      RUN: begin
        rem_d         = step_rem;
        quot_d[cnt_q] = step_q_bit;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        // No new accept here: in_ready is low for the whole of DONE.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      operand_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs come straight from registers; the remainder top bit is always
  // zero once a step has completed because the remainder stays < MODULUS.
  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_residue  = rem_q[OUT_W-1:0];
  assign out_quotient = quot_q;

endmodule
